// File: rtl/serial_word_rx_if.sv
// Serial-in / word-out bundle for serial_word_rx.
// master = stimulus/consumer side, slave = receiver.
interface serial_word_rx_if #(
    parameter int N = 8
);
    logic         Sin_valid;
    logic         Sin;
    logic [N-1:0] Dout;
    logic         Dout_valid;
    logic         Dout_ready;
    logic         ParityErr;
    logic         FrameErr;
    logic         Overrun;
    logic         Busy;

    modport master (
        output Sin_valid, Sin, Dout_ready,
        input  Dout, Dout_valid, ParityErr,
        input  FrameErr, Overrun, Busy
    );

    modport slave (
        input  Sin_valid, Sin, Dout_ready,
        output Dout, Dout_valid, ParityErr,
        output FrameErr, Overrun, Busy
    );
endinterface

// File: rtl/serial_word_rx.sv
// Framed serial receiver: start, N data bits MSB first,
// optional even parity, stop; words out on valid/ready.
module serial_word_rx #(
    parameter int N         = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input logic            clk,
    input logic            reset_n,
    serial_word_rx_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   asm_q, asm_d;
    logic           perr_q, perr_d;
    logic [N-1:0]   dout_q, dout_d;
    logic           dval_q, dval_d;
    logic           derr_q, derr_d;
    logic           ferr_q, ferr_d;
    logic           ovr_q, ovr_d;
    logic           done;

    // Frame FSM: advances only on bit strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        perr_d  = perr_q;
        ferr_d  = 1'b0;
        done    = 1'b0;
        if (bus.Sin_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.Sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    asm_d = {asm_q[N-2:0], bus.Sin};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    perr_d  = (^asm_q) ^ bus.Sin;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (bus.Sin) begin
                        done = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Output register: load on completion unless full and held.
    always_comb begin
        dout_d = dout_q;
        derr_d = derr_q;
        dval_d = dval_q;
        ovr_d  = 1'b0;
        if (dval_q && bus.Dout_ready) begin
            dval_d = 1'b0;
        end
        if (done) begin
            if (!dval_q || bus.Dout_ready) begin
                dout_d = asm_q;
                derr_d = PARITY_EN ? perr_q : 1'b0;
                dval_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            perr_q  <= 1'b0;
            dout_q  <= '0;
            dval_q  <= 1'b0;
            derr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            perr_q  <= perr_d;
            dout_q  <= dout_d;
            dval_q  <= dval_d;
            derr_q  <= derr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.Dout       = dout_q;
    assign bus.Dout_valid = dval_q;
    assign bus.ParityErr  = derr_q;
    assign bus.FrameErr   = ferr_q;
    assign bus.Overrun    = ovr_q;
    assign bus.Busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: frame-level model plus
// directed frames on an N=8/parity and an N=4/no-parity receiver.
module tb_serial_word_rx;
    logic clk = 1'b0;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    serial_word_rx_if #(.N(8)) i8 ();
    serial_word_rx_if #(.N(4)) i4 ();

    serial_word_rx #(.N(8), .PARITY_EN(1'b1)) u8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (i8)
    );

    serial_word_rx #(.N(4), .PARITY_EN(1'b0)) u4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (i4)
    );

    always #5 clk = ~clk;

    // Frame-level model: collects strobed bits after a start
    // bit, judges the whole frame once its length is reached.
    logic [7:0]  m_dout [2] = '{8'h0, 8'h0};
    logic        m_dval [2] = '{1'b0, 1'b0};
    logic        m_perr [2] = '{1'b0, 1'b0};
    logic        m_ferr [2] = '{1'b0, 1'b0};
    logic        m_ovr  [2] = '{1'b0, 1'b0};
    int          m_cnt  [2] = '{0, 0};
    logic [15:0] m_bits [2] = '{16'h0, 16'h0};

    task automatic mstep(input int id, input int n, input int p,
                         input logic sv, input logic s,
                         input logic rdy);
        logic        acc;
        logic        stp;
        logic        par;
        logic [15:0] w;
        acc = m_dval[id] && rdy;
        m_ferr[id] = 1'b0;
        m_ovr[id]  = 1'b0;
        if (sv) begin
            if (m_cnt[id] == 0) begin
                if (!s) m_cnt[id] = 1;
            end else begin
                m_bits[id] = {m_bits[id][14:0], s};
                m_cnt[id]  = m_cnt[id] + 1;
                if (m_cnt[id] == n + p + 2) begin
                    stp = m_bits[id][0];
                    par = m_bits[id][1];
                    w   = (m_bits[id] >> (1 + p)) & 16'((1 << n) - 1);
                    m_cnt[id] = 0;
                    if (!stp) begin
                        m_ferr[id] = 1'b1;
                    end else if (m_dval[id] && !rdy) begin
                        m_ovr[id] = 1'b1;
                    end else begin
                        m_dout[id] = w[7:0];
                        m_perr[id] = (p != 0) && ((^w) ^ par);
                        m_dval[id] = 1'b1;
                        acc = 1'b0;
                    end
                end
            end
        end
        if (acc) m_dval[id] = 1'b0;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_dout[k] = '0;
                m_dval[k] = 1'b0;
                m_perr[k] = 1'b0;
                m_ferr[k] = 1'b0;
                m_ovr[k]  = 1'b0;
                m_cnt[k]  = 0;
                m_bits[k] = '0;
            end
        end else begin
            mstep(0, 8, 1, i8.Sin_valid, i8.Sin, i8.Dout_ready);
            mstep(1, 4, 0, i4.Sin_valid, i4.Sin, i4.Dout_ready);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        chk("dout8", 32'(i8.Dout), 32'(m_dout[0]));
        chk("dval8", 32'(i8.Dout_valid), 32'(m_dval[0]));
        if (m_dval[0])
            chk("perr8", 32'(i8.ParityErr), 32'(m_perr[0]));
        chk("ferr8", 32'(i8.FrameErr), 32'(m_ferr[0]));
        chk("ovr8", 32'(i8.Overrun), 32'(m_ovr[0]));
        chk("busy8", 32'(i8.Busy), 32'(m_cnt[0] != 0));
        chk("dout4", 32'(i4.Dout), 32'(m_dout[1][3:0]));
        chk("dval4", 32'(i4.Dout_valid), 32'(m_dval[1]));
        if (m_dval[1])
            chk("perr4", 32'(i4.ParityErr), 32'(m_perr[1]));
        chk("ferr4", 32'(i4.FrameErr), 32'(m_ferr[1]));
        chk("ovr4", 32'(i4.Overrun), 32'(m_ovr[1]));
        chk("busy4", 32'(i4.Busy), 32'(m_cnt[1] != 0));
    end

    task automatic drv(input int id, input logic v, input logic s);
        if (id == 0) begin
            i8.Sin_valid = v;
            i8.Sin       = s;
        end else begin
            i4.Sin_valid = v;
            i4.Sin       = s;
        end
    endtask

    task automatic strobe(input int id, input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            drv(id, 1'b0, 1'($urandom));
            @(posedge clk);
            #1;
        end
        drv(id, 1'b1, b);
        @(posedge clk);
        #1;
        drv(id, 1'b0, b);
    endtask

    task automatic frame(input int id, input int n, input int p,
                         input logic [7:0] w, input logic pflip,
                         input logic stp, input int gap,
                         input logic rdy_stop);
        logic pb;
        pb = pflip;
        strobe(id, 1'b0, gap);
        for (int i = n - 1; i >= 0; i--) begin
            strobe(id, w[i], gap);
            pb = pb ^ w[i];
        end
        if (p != 0) strobe(id, pb, gap);
        if (rdy_stop) i8.Dout_ready = 1'b1;
        strobe(id, stp, gap);
        i8.Dout_ready = 1'b0;
    endtask

    task automatic accept(input int id);
        if (id == 0) i8.Dout_ready = 1'b1;
        else i4.Dout_ready = 1'b1;
        @(posedge clk);
        #1;
        i8.Dout_ready = 1'b0;
        i4.Dout_ready = 1'b0;
    endtask

    task automatic idle(input int c);
        for (int k = 0; k < c; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_d8"}, 32'(i8.Dout), 32'h0);
        chk({nm, "_v8"}, 32'(i8.Dout_valid), 32'h0);
        chk({nm, "_p8"}, 32'(i8.ParityErr), 32'h0);
        chk({nm, "_f8"}, 32'(i8.FrameErr), 32'h0);
        chk({nm, "_o8"}, 32'(i8.Overrun), 32'h0);
        chk({nm, "_b8"}, 32'(i8.Busy), 32'h0);
        chk({nm, "_d4"}, 32'(i4.Dout), 32'h0);
        chk({nm, "_v4"}, 32'(i4.Dout_valid), 32'h0);
        chk({nm, "_b4"}, 32'(i4.Busy), 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        drv(0, 1'b0, 1'b1);
        drv(1, 1'b0, 1'b1);
        i8.Dout_ready = 1'b0;
        i4.Dout_ready = 1'b0;
        idle(3);
        chk_zero("rst");
        reset_n = 1'b1;
        idle(2);

        // A5 with correct (even) parity 0, one bit per clk.
        frame(0, 8, 1, 8'hA5, 1'b0, 1'b1, 0, 1'b0);
        chk("a5_dout", 32'(i8.Dout), 32'hA5);
        chk("a5_val", 32'(i8.Dout_valid), 32'h1);
        chk("a5_perr", 32'(i8.ParityErr), 32'h0);
        accept(0);
        chk("a5_clr", 32'(i8.Dout_valid), 32'h0);

        // 3C with parity bit flipped to 1.
        frame(0, 8, 1, 8'h3C, 1'b1, 1'b1, 0, 1'b0);
        idle(3);
        chk("3c_dout", 32'(i8.Dout), 32'h3C);
        chk("3c_perr", 32'(i8.ParityErr), 32'h1);
        accept(0);

        // FF with stop bit 0, then a clean 01.
        frame(0, 8, 1, 8'hFF, 1'b0, 1'b0, 0, 1'b0);
        chk("fe_pulse", 32'(i8.FrameErr), 32'h1);
        chk("fe_val", 32'(i8.Dout_valid), 32'h0);
        chk("fe_busy", 32'(i8.Busy), 32'h0);
        idle(1);
        chk("fe_end", 32'(i8.FrameErr), 32'h0);
        frame(0, 8, 1, 8'h01, 1'b0, 1'b1, 0, 1'b0);
        chk("01_dout", 32'(i8.Dout), 32'h01);
        accept(0);

        // Back-to-back 11, 22 with no acceptance.
        frame(0, 8, 1, 8'h11, 1'b0, 1'b1, 0, 1'b0);
        frame(0, 8, 1, 8'h22, 1'b0, 1'b1, 0, 1'b0);
        chk("ov_pulse", 32'(i8.Overrun), 32'h1);
        chk("ov_dout", 32'(i8.Dout), 32'h11);
        accept(0);

        // Same, but ready exactly at the second stop edge.
        frame(0, 8, 1, 8'h11, 1'b0, 1'b1, 0, 1'b0);
        frame(0, 8, 1, 8'h22, 1'b0, 1'b1, 0, 1'b1);
        chk("sim_ovr", 32'(i8.Overrun), 32'h0);
        chk("sim_dout", 32'(i8.Dout), 32'h22);
        chk("sim_val", 32'(i8.Dout_valid), 32'h1);
        accept(0);

        // Sparse strobes with noise between them.
        frame(0, 8, 1, 8'hC3, 1'b0, 1'b1, 2, 1'b0);
        chk("c3_dout", 32'(i8.Dout), 32'hC3);
        chk("c3_perr", 32'(i8.ParityErr), 32'h0);
        accept(0);

        // Mid-frame async reset after 4 data bits.
        strobe(0, 1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(0, 1'b1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("mid8");
        idle(1);
        reset_n = 1'b1;
        idle(1);
        frame(0, 8, 1, 8'h5A, 1'b0, 1'b1, 0, 1'b0);
        chk("5a_dout", 32'(i8.Dout), 32'h5A);
        chk("5a_perr", 32'(i8.ParityErr), 32'h0);
        accept(0);

        // N=4, no parity: 9, then reset mid-frame, then 9 again.
        frame(1, 4, 0, 8'h09, 1'b0, 1'b1, 0, 1'b0);
        chk("n4_dout", 32'(i4.Dout), 32'h9);
        chk("n4_val", 32'(i4.Dout_valid), 32'h1);
        strobe(1, 1'b0, 0);
        for (int i = 0; i < 3; i++) strobe(1, 1'b1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("mid4");
        idle(1);
        reset_n = 1'b1;
        idle(1);
        frame(1, 4, 0, 8'h09, 1'b0, 1'b1, 1, 1'b0);
        chk("n4b_dout", 32'(i4.Dout), 32'h9);
        chk("n4b_perr", 32'(i4.ParityErr), 32'h0);
        accept(1);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel framed receiver: consumes a strobed serial bit stream, MSB first, such as the serial output of the team's shift register stage. It strips start/parity/stop framing, assembles N-bit words, and presents them on a valid/ready output with error flags. It sits directly downstream of the serializing shift register, on the far side of any serial link between them.

## Interface
Parameters:
- N, 8, data bits per word (N >= 2)
- PARITY_EN, 1, 1 = an even-parity bit follows the data bits; 0 = no parity bit

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- Sin_valid  input  1  bit strobe; Sin is sampled only on cycles where this is high
- Sin  input  1  serial data bit
- Dout  output  N  received word, MSB = first data bit received
- Dout_valid  output  1  Dout, ParityErr are valid
- Dout_ready  input  1  consumer accepts the word when Dout_valid & Dout_ready
- ParityErr  output  1  parity mismatch for the word on Dout; qualified by Dout_valid
- FrameErr  output  1  one-cycle pulse: stop bit sampled as 0, word discarded
- Overrun  output  1  one-cycle pulse: completed word dropped because the output register was full
- Busy  output  1  high whenever the FSM is not in IDLE

## Operation
- Frame format on strobed bits: start (0), N data bits MSB first, parity (if PARITY_EN), stop (1).
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on Sin_valid cycles.
  - IDLE: Sin=0 -> DATA, bit counter cleared. Sin=1 -> stay in IDLE (line idle).
  - DATA: shift Sin into the LSB of the assembly register (shift left). After the N-th bit, go to PARITY if PARITY_EN, else to STOP.
  - PARITY: record `perr = (XOR of the N data bits) ^ Sin`. Go to STOP.
  - STOP: Sin=1 -> word complete, go to IDLE. Sin=0 -> FrameErr pulse, discard the word, go to IDLE. There is no resync search; the next 0 is treated as a start bit.
- Bit counter is ceil(log2(N+1)) bits wide and never wraps mid-frame.
- Output register (Dout, ParityErr, Dout_valid) on word completion:
  - empty, or full and accepted in the same cycle: load the word and perr, Dout_valid=1.
  - full and not accepted in the same cycle: keep the old word, pulse Overrun, drop the new word.
- Handshake: Dout/ParityErr stay stable while Dout_valid=1 and Dout_ready=0. Dout_ready while Dout_valid=0 has no effect.
- The receive FSM never stalls on the output side; a frame always completes.
- Reset (async assert, any state or mid-frame): FSM=IDLE, counter=0, assembly register=0, Dout=0, Dout_valid=0, ParityErr=0, FrameErr=0, Overrun=0, Busy=0. Deassertion is used synchronously.

## Timing
- Dout_valid rises on the clk edge that samples the stop bit, so it is visible the cycle after the stop strobe. There is no other latency.
- Back-to-back frames are supported: a start bit may arrive on the strobe immediately after the stop bit.
- Sin_valid may be high every cycle (one bit per clk) or sparse; gaps of any length are allowed between strobes.
- FrameErr and Overrun are high for exactly one cycle, on the edge that samples the stop bit.
- Busy is high from the start-bit edge through the stop-bit edge, exclusive.
- Word accepted at edge E: Dout_valid=0 after E unless a new word also completes at E.

## Test plan
- Basic, N=8, PARITY_EN=1, Sin_valid every cycle: send 0,1010_0101,0(parity),1 -> Dout=8'hA5, Dout_valid=1 one cycle after the stop, ParityErr=0; Dout_ready=1 clears Dout_valid next edge.
- Parity error: send 8'h3C with parity bit 1 -> Dout=8'h3C, ParityErr=1 held until accepted.
- Framing error: 8'hFF with stop bit 0 -> FrameErr one-cycle pulse, Dout_valid stays 0, Busy=0. A following valid frame with 8'h01 is received correctly.
- Overrun: two back-to-back frames (8'h11, 8'h22) with Dout_ready=0 -> Dout=8'h11 retained, Overrun pulses at the second stop. Simultaneous case: Dout_ready=1 exactly at the second stop edge -> no Overrun, Dout=8'h22.
- Sparse strobes: 8'hC3 with Sin_valid high every 3rd cycle and noise on Sin between strobes -> Dout=8'hC3, ParityErr=0.
- Reset mid-frame: assert reset_n=0 after 4 data bits, no clk edge needed -> all outputs 0 immediately. After release, a full frame 8'h5A is received correctly, with no carry-over of the partial bits. Repeat with PARITY_EN=0, N=4, nibble 4'h9.
